// File: rtl/c1_master.sv
// C1 bus master: accepts one request at a time, runs the two-cycle address
// phase, a turnaround cycle, then waits (bounded) for the cache response
// code and returns the captured read data or a timeout indication.
module c1_master #(
  parameter int ADDR_W   = 19,
  parameter int OFFSET_W = 5,
  parameter int BUS_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_cmd,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [2*BUS_W-1:0]     req_wdata,
  output logic                   resp_valid,
  output logic [2*BUS_W-1:0]     resp_rdata,
  output logic                   resp_timeout,
  output logic [ADDR_W-OFFSET_W-1:0] bus_addr,
  output logic [2:0]             bus_cmd_out,
  output logic                   bus_cmd_oe,
  input  logic [2:0]             bus_cmd_in,
  output logic [BUS_W-1:0]       bus_data_out,
  output logic                   bus_data_oe,
  input  logic [BUS_W-1:0]       bus_data_in
);

  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR1 = 3'd1;
  localparam logic [2:0] S_ADDR2 = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP2 = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_READ8   = 3'd1;
  localparam logic [2:0] CMD_READ16  = 3'd2;
  localparam logic [2:0] CMD_READ32  = 3'd3;
  localparam logic [2:0] CMD_WRITE32 = 3'd7;
  localparam logic [2:0] CMD_RESP    = 3'd7;

  logic [2:0]          r_state;
  logic [2:0]          r_cmd;
  logic [OFFSET_W-1:0] r_off;
  logic [2*BUS_W-1:0]  r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*BUS_W-1:0]  r_rdata;
  logic                r_timeout;
  logic [LINE_W-1:0]   r_bus_addr;

  logic                w_hs;
  logic                w_is_write;
  logic [LINE_W-1:0]   w_off_addr;

  // First response beat: narrow reads are zero-extended, READ32 fills the
  // low half (high half arrives in RESP2), writes/INV_LINE return zero.
  function automatic logic [2*BUS_W-1:0] f_capture(input logic [2:0] cmd,
                                                   input logic [BUS_W-1:0] d);
    logic [2*BUS_W-1:0] v;
    v = '0;
    case (cmd)
      CMD_READ8:  v[7:0] = d[7:0];
      CMD_READ16: v[BUS_W-1:0] = d;
      CMD_READ32: v[BUS_W-1:0] = d;
      default:    v = '0;
    endcase
    return v;
  endfunction

  assign w_hs       = req_valid && (r_state == S_IDLE);
  assign w_is_write = r_cmd[2] && (r_cmd[1:0] != 2'b00);

  // Second address beat carries only the in-line offset, zero-extended.
  always_comb begin
    w_off_addr = '0;
    w_off_addr[OFFSET_W-1:0] = r_off;
  end

  // Transaction FSM, request latch, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_NOP;
      r_off      <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_timeout  <= 1'b0;
      r_bus_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A NOP handshake is simply consumed.
          if (w_hs && (req_cmd != CMD_NOP)) begin
            r_cmd      <= req_cmd;
            r_off      <= req_addr[OFFSET_W-1:0];
            r_wdata    <= req_wdata;
            r_bus_addr <= req_addr[ADDR_W-1:OFFSET_W];
            r_state    <= S_ADDR1;
          end
        end
        S_ADDR1: begin
          r_bus_addr <= w_off_addr;
          r_state    <= S_ADDR2;
        end
        S_ADDR2: r_state <= S_TURN;
        S_TURN: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the last permitted cycle beats the timeout.
          if (bus_cmd_in == CMD_RESP) begin
            r_rdata   <= f_capture(r_cmd, bus_data_in);
            r_timeout <= 1'b0;
            r_state   <= (r_cmd == CMD_READ32) ? S_RESP2 : S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rdata   <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP2: begin
          r_rdata[2*BUS_W-1:BUS_W] <= bus_data_in;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus drive decode: values are forced to zero whenever not enabled.
  always_comb begin
    bus_cmd_oe   = 1'b0;
    bus_cmd_out  = CMD_NOP;
    bus_data_oe  = 1'b0;
    bus_data_out = '0;
    case (r_state)
      S_ADDR1: begin
        bus_cmd_oe  = 1'b1;
        bus_cmd_out = r_cmd;
        if (w_is_write) begin
          bus_data_oe  = 1'b1;
          bus_data_out = r_wdata[BUS_W-1:0];
        end
      end
      S_ADDR2: begin
        bus_cmd_oe  = 1'b1;
        bus_cmd_out = CMD_NOP;
        if (r_cmd == CMD_WRITE32) begin
          bus_data_oe  = 1'b1;
          bus_data_out = r_wdata[2*BUS_W-1:BUS_W];
        end
      end
      default: ;
    endcase
  end

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_DONE);
  assign resp_rdata   = r_rdata;
  assign resp_timeout = r_timeout;
  assign bus_addr     = r_bus_addr;

endmodule

// File: tb/tb_c1_master.sv
// Bench for c1_master: directed and random transactions, bus-phase checks
// in the stimulus thread, response checks through a scoreboard queue.
module tb_c1_master;
  localparam int ADDR_W   = 19;
  localparam int OFFSET_W = 5;
  localparam int BUS_W    = 16;
  localparam int TO       = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_timeout;
  logic [13:0] bus_addr;
  logic [2:0]  bus_cmd_out;
  logic        bus_cmd_oe;
  logic [2:0]  bus_cmd_in;
  logic [15:0] bus_data_out;
  logic        bus_data_oe;
  logic [15:0] bus_data_in;

  c1_master #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .BUS_W(BUS_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
    .bus_addr(bus_addr), .bus_cmd_out(bus_cmd_out), .bus_cmd_oe(bus_cmd_oe),
    .bus_cmd_in(bus_cmd_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .bus_data_in(bus_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        tmo;
    int          cycle;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: what a transaction returns and in which cycle, given the
  // WAIT-cycle index d at which the cache answers (d >= TO: never).
  function automatic exp_t model(input logic [2:0] cmd, input int d,
                                 input logic [15:0] lo, input logic [15:0] hi,
                                 input int a1);
    exp_t e;
    if (d >= TO) begin
      e.rdata = 32'h0;
      e.tmo   = 1'b1;
      e.cycle = a1 + 3 + TO;
    end else begin
      e.tmo = 1'b0;
      case (cmd)
        3'd1:    e.rdata = 32'(lo & 16'h00FF);
        3'd2:    e.rdata = 32'(lo);
        3'd3:    e.rdata = {hi, lo};
        default: e.rdata = 32'h0;
      endcase
      e.cycle = a1 + 4 + d + ((cmd == 3'd3) ? 1 : 0);
    end
    return e;
  endfunction

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", resp_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_timeout", resp_timeout, e.tmo);
        chk("resp_cycle", cyc, e.cycle);
        chk("ready_in_done", req_ready, 1'b0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", req_ready, 1'b1);
  endtask

  task automatic do_txn(input logic [2:0] cmd, input logic [18:0] addr,
                        input logic [31:0] wd, input int d,
                        input logic [15:0] lo, input logic [15:0] hi);
    int a1;
    logic [13:0] line;
    logic [13:0] offa;
    logic wr;
    line = addr[18:5];
    offa = {9'd0, addr[4:0]};
    wr   = (cmd >= 3'd5);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    a1 = cyc;
    sb.push_back(model(cmd, d, lo, hi, a1));
    // Junk on the request port must be ignored while busy.
    req_cmd = 3'($urandom); req_addr = 19'($urandom); req_wdata = $urandom;
    @(negedge clk);
    chk("a1_cmd_oe", bus_cmd_oe, 1'b1);
    chk("a1_cmd_out", bus_cmd_out, cmd);
    chk("a1_addr", bus_addr, line);
    chk("a1_data_oe", bus_data_oe, wr);
    chk("a1_data_out", bus_data_out, wr ? wd[15:0] : 16'h0);
    bus_cmd_in = 3'($urandom_range(0, 7)); bus_data_in = 16'($urandom);
    @(negedge clk);
    chk("a2_cmd_oe", bus_cmd_oe, 1'b1);
    chk("a2_cmd_out", bus_cmd_out, 3'd0);
    chk("a2_addr", bus_addr, offa);
    chk("a2_data_oe", bus_data_oe, cmd == 3'd7);
    chk("a2_data_out", bus_data_out, (cmd == 3'd7) ? wd[31:16] : 16'h0);
    bus_cmd_in = 3'($urandom_range(0, 7));
    @(negedge clk);
    chk("turn_oe", {bus_cmd_oe, bus_data_oe}, 2'b00);
    chk("turn_out", {bus_cmd_out, bus_data_out}, 19'h0);
    chk("turn_addr_hold", bus_addr, offa);
    bus_cmd_in = 3'd7;   // response code outside WAIT is ignored
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("wait_oe", {bus_cmd_oe, bus_data_oe}, 2'b00);
      chk("wait_out", {bus_cmd_out, bus_data_out}, 19'h0);
      if (i == d) begin
        bus_cmd_in = 3'd7; bus_data_in = lo;
        break;
      end
      bus_cmd_in = 3'($urandom_range(0, 6)); bus_data_in = 16'($urandom);
    end
    if (d < TO && cmd == 3'd3) begin
      @(negedge clk);
      bus_cmd_in = 3'($urandom_range(0, 7)); bus_data_in = hi;
    end
    @(negedge clk);
    req_valid = 1'b0; bus_cmd_in = 3'd0; bus_data_in = 16'h0;
    wait_ready();
  endtask

  task automatic do_nop();
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_cmd = 3'd0; req_addr = 19'($urandom); req_wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    chk("nop_ready", req_ready, 1'b1);
    chk("nop_oe", {bus_cmd_oe, bus_data_oe}, 2'b00);
    @(negedge clk);
    chk("nop_oe2", {bus_cmd_oe, bus_data_oe}, 2'b00);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_timeout"}, resp_timeout, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr, 14'h0);
    chk({tag, "_oe"}, {bus_cmd_oe, bus_data_oe}, 2'b00);
    chk({tag, "_out"}, {bus_cmd_out, bus_data_out}, 19'h0);
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_cmd = 3'd2; req_addr = 19'h7FFFF; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);   // now in the first WAIT cycle
    bus_cmd_in = 3'd7; bus_data_in = 16'hBEEF;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus_cmd_in = 3'd0; bus_data_in = 16'h0;
    check_reset_state("rst_wait");
    repeat (6) @(negedge clk);
    chk("rst_wait_idle", req_ready, 1'b1);
  endtask

  task automatic reset_with_handshake();
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_cmd = 3'd1; req_addr = 19'h12345; reset = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    chk("rst_hs_ready", req_ready, 1'b1);
    chk("rst_hs_oe", bus_cmd_oe, 1'b0);
    @(negedge clk);
    chk("rst_hs_oe2", bus_cmd_oe, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_cmd = 3'd0; req_addr = '0; req_wdata = '0;
    bus_cmd_in = 3'd0; bus_data_in = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    do_txn(3'd1, 19'h00050, 32'h0, 0, 16'hABCD, 16'h0);
    do_txn(3'd7, 19'h2A5C3, 32'h12345678, 1, 16'hFFFF, 16'h0);
    do_txn(3'd3, 19'h01234, 32'h0, 2, 16'h1111, 16'h2222);
    do_txn(3'd2, 19'h3C0DE, 32'h0, TO, 16'h5555, 16'h0);
    do_txn(3'd2, 19'h00001, 32'h0, TO - 1, 16'h8001, 16'h0);
    do_txn(3'd3, 19'h7FFFF, 32'h0, TO - 1, 16'hA5A5, 16'h5A5A);
    do_txn(3'd4, 19'h10000, 32'hDEADBEEF, 0, 16'h1234, 16'h0);
    do_nop();
    reset_in_wait();
    reset_with_handshake();

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) do_nop();
      do_txn(3'($urandom_range(1, 7)), 19'($urandom), $urandom,
             int'($urandom_range(0, TO)), 16'($urandom), 16'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/c1_master.md
C1_MASTER -- requirements
Module: c1_master

Parameters
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDR_W  19  full byte address width (tag+set+offset)
  OFFSET_W  5  in-line offset width
  BUS_W  16  C1 data bus width
  TIMEOUT  255  max WAIT cycles before abort (>=1)

Interface
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all state on posedge
  reset  in  1  synchronous, active-high
  req_valid  in  1  request present
  req_ready  out  1  master can accept request
  req_cmd  in  3  C1 command code (0..7)
  req_addr  in  ADDR_W  byte address
  req_wdata  in  2*BUS_W  write data, low half first
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  2*BUS_W  read data, valid with resp_valid
  resp_timeout  out  1  completion was a timeout, valid with resp_valid
  bus_addr  out  ADDR_W-OFFSET_W  C1 address lines
  bus_cmd_out  out  3  C1 command drive value
  bus_cmd_oe  out  1  C1 command drive enable
  bus_cmd_in  in  3  C1 command sampled from bus
  bus_data_out  out  BUS_W  C1 data drive value
  bus_data_oe  out  1  C1 data drive enable
  bus_data_in  in  BUS_W  C1 data sampled from bus
REQ-003 Command codes SHALL be NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7; cache response code on bus_cmd_in SHALL be 7.

Function
REQ-004 FSM states SHALL be IDLE, ADDR1, ADDR2, TURN, WAIT, RESP2, DONE.
REQ-005 req_ready SHALL be 1 only in IDLE; handshake occurs on a cycle with req_valid&req_ready.
REQ-006 Handshake with req_cmd=NOP SHALL be consumed with no bus activity and no resp_valid; FSM stays IDLE.
REQ-007 Handshake with non-NOP SHALL latch cmd, addr, wdata and enter ADDR1 next cycle; inputs are ignored until back in IDLE.
REQ-008 ADDR1 SHALL drive bus_cmd_oe=1, bus_cmd_out=cmd, bus_addr=addr[ADDR_W-1:OFFSET_W]; for writes bus_data_oe=1, bus_data_out=wdata[BUS_W-1:0]; else bus_data_oe=0.
REQ-009 ADDR2 SHALL drive bus_cmd_oe=1, bus_cmd_out=NOP, bus_addr={zeros, addr[OFFSET_W-1:0]}; bus_data_oe=1 with wdata[2*BUS_W-1:BUS_W] only for WRITE32, else 0.
REQ-010 TURN SHALL last exactly one cycle with bus_cmd_oe=0, bus_data_oe=0 (bus turnaround); TURN->WAIT.
REQ-011 In WAIT, all oe SHALL be 0; bus_cmd_in==7 SHALL be a response: READ32 captures bus_data_in as rdata low half and goes RESP2; other commands capture per REQ-012 and go DONE.
REQ-012 Capture rules: READ8 rdata={zeros, bus_data_in[7:0]}; READ16 rdata={zeros, bus_data_in}; writes and INV_LINE rdata=0.
REQ-013 RESP2 SHALL capture bus_data_in as rdata high half unconditionally and go DONE.
REQ-014 WAIT cycle counter SHALL reset to 0 on entry; if TIMEOUT WAIT cycles pass without response, go DONE with rdata=0, resp_timeout=1; response on the final permitted cycle wins over timeout.
REQ-015 DONE SHALL assert resp_valid=1 for exactly one cycle with resp_rdata/resp_timeout held stable, then go IDLE.
REQ-016 Latency: handshake cycle 0, ADDR1 cycle 1, ADDR2 cycle 2, TURN cycle 3, WAIT from cycle 4; response in cycle k gives resp_valid in k+1 (k+2 for READ32).
REQ-017 bus_cmd_out and bus_data_out SHALL be 0 whenever their oe is 0; bus_addr holds last value outside ADDR1/ADDR2.
REQ-018 bus_cmd_in==7 outside WAIT SHALL be ignored.

Reset
REQ-019 reset SHALL, on the next posedge, force IDLE and set req_ready=1, resp_valid=0, resp_rdata=0, resp_timeout=0, bus_addr=0, all oe and drive values 0, counter 0.
REQ-020 reset in any state (mid-transaction) SHALL abort with no resp_valid; reset dominates a simultaneous handshake.

Verification
REQ-021 READ8 addr=19'h00050, response in cycle 4 with data 16'hABCD -> ADDR1 bus_addr=14'h0002, ADDR2 bus_addr=5'h10, resp_valid cycle 5, rdata=32'h000000CD.
REQ-022 WRITE32 wdata=32'h12345678 -> data 16'h5678 in ADDR1, 16'h1234 in ADDR2, oe low in TURN; response -> rdata=0, timeout=0.
REQ-023 READ32, response with 16'h1111 then 16'h2222 next cycle -> rdata=32'h22221111, resp_valid one cycle.
REQ-024 TIMEOUT=4, READ16, no response -> resp_valid cycle 8 with resp_timeout=1, rdata=0; then req_ready=1.
REQ-025 reset asserted during WAIT -> IDLE next cycle, no resp_valid, all oe 0; NOP request -> no bus activity.
